// File: rtl/reg_wr_arb.sv
// Round-robin arbiter sharing the coefficient-register write bus between NREQ requesters.
// Optional define REG_WR_ARB_LOCK_EN adds req_lock and an ARB/LOCKED ownership FSM.
module reg_wr_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 32,
    parameter int GW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
`ifdef REG_WR_ARB_LOCK_EN
    input  logic [NREQ-1:0]      req_lock,
`endif
    input  logic                 reg_stall,
    output logic                 reg_wea,
    output logic [AW-1:0]        reg_addr,
    output logic [DW-1:0]        reg_wdata,
    output logic [GW-1:0]        grant_id
);

    logic [GW-1:0]   ptr;
    logic [GW-1:0]   ptr_nxt;
    logic [GW-1:0]   sel;
    logic [GW-1:0]   sel_inc;
    logic            found;
    logic            xfer;
    logic [NREQ-1:0] elig;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

`ifdef REG_WR_ARB_LOCK_EN
    typedef enum logic {ARB, LOCKED} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] owner;
    logic [GW-1:0] owner_nxt;
    logic          sel_lock;
`endif

    // While locked, only the owner may compete even if it is currently idle.
    always_comb begin
        elig = req_valid;
`ifdef REG_WR_ARB_LOCK_EN
        if (state == LOCKED) begin
            elig = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (owner == GW'(i)) begin
                    elig[i] = req_valid[i];
                end
            end
        end
`endif
    end

    // Outer loop walks priority order from ptr, so the first hit wins.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        sel_addr  = '0;
        sel_wdata = '0;
`ifdef REG_WR_ARB_LOCK_EN
        sel_lock  = 1'b0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && elig[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                    found     = 1'b1;
                    sel       = GW'(i);
                    sel_addr  = req_addr[i*AW +: AW];
                    sel_wdata = req_wdata[i*DW +: DW];
`ifdef REG_WR_ARB_LOCK_EN
                    sel_lock  = req_lock[i];
`endif
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_b && !reg_stall && found) begin
            for (int i = 0; i < NREQ; i++) begin
                req_ready[i] = (sel == GW'(i));
            end
        end
    end

    assign xfer    = |(req_valid & req_ready);
    assign sel_inc = (sel == GW'(NREQ - 1)) ? '0 : sel + 1'b1;

    // A locking transfer freezes ptr; the releasing transfer moves it past the owner.
    always_comb begin
        ptr_nxt = ptr;
`ifdef REG_WR_ARB_LOCK_EN
        state_nxt = state;
        owner_nxt = owner;
        if (xfer) begin
            case (state)
                ARB: begin
                    if (sel_lock) begin
                        state_nxt = LOCKED;
                        owner_nxt = sel;
                    end else begin
                        ptr_nxt = sel_inc;
                    end
                end
                LOCKED: begin
                    if (!sel_lock) begin
                        state_nxt = ARB;
                        ptr_nxt   = sel_inc;
                    end
                end
                default: state_nxt = ARB;
            endcase
        end
`else
        if (xfer) begin
            ptr_nxt = sel_inc;
        end
`endif
    end

`ifdef REG_WR_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= ARB;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            reg_wea   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            grant_id  <= '0;
            ptr       <= '0;
        end else begin
            reg_wea <= xfer;
            ptr     <= ptr_nxt;
            if (xfer) begin
                reg_addr  <= sel_addr;
                reg_wdata <= sel_wdata;
                grant_id  <= sel;
            end
        end
    end

endmodule
